// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle datapath control FSM:
//   - state_t      : 4-bit binary state encoding
//   - OP_*         : supported instruction opcodes (IR[31:26])
//   - SRCB_*, ALUOP_*, PCSRC_* : datapath mux select encodings
//   - ctrl_t       : control word driven into the datapath
//   - decode_target / op_is_legal : opcode dispatch helpers
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_RD    = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WR    = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_RSVD  = 2'd3;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // State entered after DECODE; FETCH doubles as the "unsupported" answer.
  function automatic state_t decode_target(input logic [OPC_W-1:0] op);
    state_t t;
    case (op)
      OP_RTYPE:     t = R_EXEC;
      OP_LW, OP_SW: t = MEM_ADDR;
      OP_BEQ:       t = BRANCH;
      OP_J:         t = JUMP;
      OP_ADDI:      t = ADDI_EXEC;
      default:      t = FETCH;
    endcase
    return t;
  endfunction

  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    return (decode_target(op) != FETCH);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the control FSM (master) and the datapath (slave).
//   opcode, mem_ready           : datapath -> control
//   pc_write .. pc_source       : control -> datapath mux selects / enables
//   illegal_op                  : control -> datapath/system, sticky error
// -----------------------------------------------------------------------------
interface multicycle_control_if #(parameter int OPCODE_W = 6);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );
endinterface

// File: rtl/multicycle_control_out_decode.sv
// -----------------------------------------------------------------------------
// mc_out_decode
// Combinational state -> control word decoder.
//   state     in  current FSM state
//   mem_ready in  memory handshake, only used to gate IR/PC load in FETCH
//   ctrl      out datapath control word
// -----------------------------------------------------------------------------
module mc_out_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Control word per state; every field not named for a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC+4 are captured only in the cycle the read completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        // speculative branch target into ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the 32-bit multicycle datapath.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   master side of multicycle_control_if (opcode/mem_ready in,
//         mux selects, write enables and illegal_op out)
// Holds the state register, the next-state logic and the sticky illegal flag;
// mc_out_decode turns the state into the datapath control word.
// -----------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               illegal_r;
  logic [OPC_W-1:0]   op_s;
  ctrl_t              ctrl_s;

  assign op_s = OPC_W'(bus.opcode);

  // State register; reset lands in S_RESET so outputs are 0 one extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky unsupported-opcode flag, raised on the DECODE -> FETCH edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if ((state_r == DECODE) && !op_is_legal(op_s)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state logic; unused encodings fall back to S_RESET.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RESET: state_nxt_s = FETCH;
      FETCH: begin
        if (bus.mem_ready) state_nxt_s = DECODE;
        else               state_nxt_s = FETCH;
      end
      DECODE: state_nxt_s = decode_target(op_s);
      MEM_ADDR: begin
        if (op_s == OP_LW)      state_nxt_s = MEM_RD;
        else if (op_s == OP_SW) state_nxt_s = MEM_WR;
        else                    state_nxt_s = FETCH;
      end
      MEM_RD: begin
        if (bus.mem_ready) state_nxt_s = MEM_WB;
        else               state_nxt_s = MEM_RD;
      end
      MEM_WR: begin
        if (bus.mem_ready) state_nxt_s = FETCH;
        else               state_nxt_s = MEM_WR;
      end
      R_EXEC:    state_nxt_s = R_WB;
      ADDI_EXEC: state_nxt_s = ADDI_WB;
      MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: state_nxt_s = FETCH;
      default:   state_nxt_s = S_RESET;
    endcase
  end

  mc_out_decode u_out_decode (
    .state     (state_r),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_s)
  );

  assign bus.pc_write      = ctrl_s.pc_write;
  assign bus.pc_write_cond = ctrl_s.pc_write_cond;
  assign bus.iord          = ctrl_s.iord;
  assign bus.mem_read      = ctrl_s.mem_read;
  assign bus.mem_write     = ctrl_s.mem_write;
  assign bus.ir_write      = ctrl_s.ir_write;
  assign bus.mem_to_reg    = ctrl_s.mem_to_reg;
  assign bus.reg_dst       = ctrl_s.reg_dst;
  assign bus.reg_write     = ctrl_s.reg_write;
  assign bus.alu_src_a     = ctrl_s.alu_src_a;
  assign bus.alu_src_b     = ctrl_s.alu_src_b;
  assign bus.alu_op        = ctrl_s.alu_op;
  assign bus.pc_source     = ctrl_s.pc_source;
  assign bus.illegal_op    = illegal_r;

endmodule
